shift_reg_universal: RTL and testbench
======================================

Name: shift_reg_universal

Overview:
- Parametrised successor to the fixed 8-stage 1-bit serial-in/serial-out register chain.
- Provides DEPTH stages of WIDTH-bit lanes with clock enable, synchronous reset to a programmable init value, parallel load, bidirectional shift, parallel readout and a fill counter.
- Used as a generic delay line, serialiser/deserialiser or small LIFO/window buffer inside datapaths.

Parameters:
WIDTH, 1, bits per stage (>=1)
DEPTH, 8, number of stages (>=2)
INIT, 0, reset value of every stage (WIDTH bits, replicated)

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  synchronous active-high reset
CE  input  1  clock enable; gates LOAD and shift
LOAD  input  1  parallel load request (effective only with CE=1)
DIR  input  1  0 = forward (stage k -> k+1), 1 = reverse (stage k+1 -> k)
SI  input  WIDTH  serial input lane
PI  input  DEPTH*WIDTH  parallel input; stage k = PI[WIDTH*(k+1)-1 : WIDTH*k]
SO  output  WIDTH  serial output lane
PO  output  DEPTH*WIDTH  parallel output, same packing as PI
COUNT  output  clog2(DEPTH+1)  number of valid stages
FULL  output  1  COUNT == DEPTH

Behaviour:
- Priority per rising edge: RESET > (CE & LOAD) > (CE & ~LOAD: shift) > hold.
- RESET=1: every stage <= INIT, COUNT <= 0; CE/LOAD/DIR ignored. Reset in the middle of a shift sequence discards all content; the first enabled shift after reset counts as COUNT=1.
- CE=1, LOAD=1: stage k <= PI slice k for all k; COUNT <= DEPTH. SI and DIR ignored.
- CE=1, LOAD=0, DIR=0: stage 0 <= SI, stage k <= stage k-1 for k>=1; old stage DEPTH-1 is discarded.
- CE=1, LOAD=0, DIR=1: stage DEPTH-1 <= SI, stage k <= stage k+1 for k<DEPTH-1; old stage 0 is discarded.
- Every shift: COUNT <= min(COUNT+1, DEPTH), saturating. COUNT never wraps and never decrements except on reset.
- CE=0: all state holds, including when LOAD=1.
- SO is combinational from registered state and current DIR: stage DEPTH-1 when DIR=0, stage 0 when DIR=1. There is no combinational path from SI to SO.
- PO mirrors the stage registers with zero added latency.
- FULL is combinational from COUNT.
- Latency: with DIR held at 0, a value on SI appears on SO after exactly DEPTH enabled edges. Disabled cycles do not count.
- DIR may change on any cycle. The new direction applies to that cycle's shift and to SO immediately.
- Reset values: SO = INIT, PO = INIT replicated, COUNT = 0, FULL = 0.
- Initial (pre-reset) register value is INIT for simulation parity with existing registers.
- Width rules: COUNT width is clog2(DEPTH+1), e.g. 4 bits for DEPTH=8. All stage data passes through unmodified; no arithmetic on data.

Decomposition:
- Shared package shift_reg_pkg holds:
  - DIR_FWD=1'b0 and DIR_REV=1'b1 constants
  - a clog2-based count-width function
  - the stage-slice index helper for PI/PO packing
- Sub-module shift_stage_reg: one WIDTH-bit register with CLK, sync RESET to INIT, CE, and a 3-input next-value select (load value, forward neighbour, reverse neighbour).
- The top instantiates DEPTH shift_stage_reg instances plus the saturating COUNT register and SO mux.

Test Plan:
- WIDTH=1, DEPTH=8, RESET then CE=1, DIR=0, SI pattern 1,0,0,0,0,0,0,0 -> SO=0 for edges 1-7, SO=1 after edge 8; COUNT reads 1..8, FULL=1 at edge 8 and stays 1.
- WIDTH=8, DEPTH=4, CE=1, LOAD=1, PI=0x44332211 -> next cycle PO=0x44332211, COUNT=4. Then DIR=1 with SI=0xAA for 4 edges -> SO sequence 0x11, 0x22, 0x33, 0x44 before each edge; PO=0xAAAAAAAA at the end.
- DEPTH=4, WIDTH=8: load 0x44332211, then CE=0 with LOAD=1 and PI=0 for 3 cycles -> PO unchanged at 0x44332211.
- Mid-stream reset: INIT=0x5, WIDTH=4, DEPTH=4, shift 2 values, assert RESET with CE=1 and LOAD=1 -> PO=0x5555, COUNT=0. The next enabled shift gives COUNT=1.
- Direction flip: DEPTH=4, WIDTH=4, PO=0x4321. DIR=0 shift with SI=0xF -> PO=0x321F. Then DIR=1 shift with SI=0xE -> PO=0xE321; SO=0x3 when DIR=0 and 0xF when DIR=1 in the intermediate state.
- Saturation: DEPTH=2, 5 consecutive enabled shifts -> COUNT=1,2,2,2,2; FULL=1 from the 2nd edge onward.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared constants, types and helpers for the universal shift register.
package shift_reg_pkg;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Next-value source for a single stage.
  typedef enum logic [1:0] {
    SEL_LOAD = 2'd0,
    SEL_FWD  = 2'd1,
    SEL_REV  = 2'd2
  } stage_sel_e;

  // Width needed to hold a count in the range 0..depth.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // LSB index of stage k within the packed PI/PO buses.
  function automatic int unsigned slice_lo(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage

// File: rtl/shift_stage_reg.sv
// One WIDTH-bit stage: sync reset to INIT, enable, 3-way next-value select.
module shift_stage_reg
  import shift_reg_pkg::*;
#(
  parameter int unsigned     WIDTH = 1,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  stage_sel_e       sel,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] fwd_val,
  input  logic [WIDTH-1:0] rev_val,
  output logic [WIDTH-1:0] q
);

  // Power-up value matches the reset value for simulation parity.
  logic [WIDTH-1:0] q_r = INIT;

  // Stage register: reset wins, otherwise update only when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= INIT;
    end else if (ce) begin
      case (sel)
        SEL_LOAD: q_r <= load_val;
        SEL_FWD:  q_r <= fwd_val;
        SEL_REV:  q_r <= rev_val;
        default:  q_r <= q_r;
      endcase
    end
  end

  assign q = q_r;

endmodule

// File: rtl/shift_reg_universal.sv
// Universal shift register: DEPTH stages of WIDTH bits with parallel load,
// bidirectional shift, parallel readout and a saturating fill counter.
module shift_reg_universal
  import shift_reg_pkg::*;
#(
  parameter int unsigned      WIDTH = 1,
  parameter int unsigned      DEPTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         CE,
  input  logic                         LOAD,
  input  logic                         DIR,
  input  logic [WIDTH-1:0]             SI,
  input  logic [DEPTH*WIDTH-1:0]       PI,
  output logic [WIDTH-1:0]             SO,
  output logic [DEPTH*WIDTH-1:0]       PO,
  output logic [count_width(DEPTH)-1:0] COUNT,
  output logic                         FULL
);

  localparam int unsigned CW = count_width(DEPTH);

  logic [WIDTH-1:0] stage [DEPTH];
  logic [WIDTH-1:0] fwd_src [DEPTH];
  logic [WIDTH-1:0] rev_src [DEPTH];
  stage_sel_e       sel;
  logic [CW-1:0]    count_r = '0;

  // One select shared by all stages: load beats shift, DIR picks the neighbour.
  always_comb begin
    sel = SEL_FWD;
    if (LOAD) begin
      sel = SEL_LOAD;
    end else if (DIR == DIR_REV) begin
      sel = SEL_REV;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    // End stages take SI from whichever side data is entering.
    if (k == 0) begin : g_first
      assign fwd_src[k] = SI;
    end else begin : g_fwd
      assign fwd_src[k] = stage[k-1];
    end
    if (k == DEPTH - 1) begin : g_last
      assign rev_src[k] = SI;
    end else begin : g_rev
      assign rev_src[k] = stage[k+1];
    end

    shift_stage_reg #(
      .WIDTH (WIDTH),
      .INIT  (INIT)
    ) u_stage (
      .clk      (CLK),
      .reset    (RESET),
      .ce       (CE),
      .sel      (sel),
      .load_val (PI[slice_lo(k, WIDTH) +: WIDTH]),
      .fwd_val  (fwd_src[k]),
      .rev_val  (rev_src[k]),
      .q        (stage[k])
    );

    assign PO[slice_lo(k, WIDTH) +: WIDTH] = stage[k];
  end

  // Fill counter: cleared by reset, forced full by load, saturating on shift.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_r <= '0;
    end else if (CE && LOAD) begin
      count_r <= CW'(DEPTH);
    end else if (CE && (count_r != CW'(DEPTH))) begin
      count_r <= count_r + CW'(1);
    end
  end

  assign COUNT = count_r;
  assign FULL  = (count_r == CW'(DEPTH));
  assign SO    = (DIR == DIR_REV) ? stage[0] : stage[DEPTH-1];

endmodule

// File: tb/tb_shift_reg_universal.sv
// Scoreboard bench: stimulus queues expected values, a negedge monitor checks them.
module tb_shift_reg_universal;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        load = 1'b0;
  logic        dir = 1'b0;
  logic [7:0]  si = '0;
  logic [31:0] pi = '0;

  logic [0:0]  a_so;  logic [7:0]  a_po;  logic [3:0] a_count; logic a_full;
  logic [7:0]  b_so;  logic [31:0] b_po;  logic [2:0] b_count; logic b_full;
  logic [3:0]  c_so;  logic [15:0] c_po;  logic [2:0] c_count; logic c_full;
  logic [0:0]  d_so;  logic [1:0]  d_po;  logic [1:0] d_count; logic d_full;

  always #5 clk = ~clk;

  shift_reg_universal #(.WIDTH(1), .DEPTH(8), .INIT(1'b0)) u_a (
    .CLK(clk), .RESET(reset), .CE(ce), .LOAD(load), .DIR(dir),
    .SI(si[0:0]), .PI(pi[7:0]), .SO(a_so), .PO(a_po), .COUNT(a_count), .FULL(a_full));

  shift_reg_universal #(.WIDTH(8), .DEPTH(4), .INIT(8'h00)) u_b (
    .CLK(clk), .RESET(reset), .CE(ce), .LOAD(load), .DIR(dir),
    .SI(si), .PI(pi), .SO(b_so), .PO(b_po), .COUNT(b_count), .FULL(b_full));

  shift_reg_universal #(.WIDTH(4), .DEPTH(4), .INIT(4'h5)) u_c (
    .CLK(clk), .RESET(reset), .CE(ce), .LOAD(load), .DIR(dir),
    .SI(si[3:0]), .PI(pi[15:0]), .SO(c_so), .PO(c_po), .COUNT(c_count), .FULL(c_full));

  shift_reg_universal #(.WIDTH(1), .DEPTH(2), .INIT(1'b0)) u_d (
    .CLK(clk), .RESET(reset), .CE(ce), .LOAD(load), .DIR(dir),
    .SI(si[0:0]), .PI(pi[1:0]), .SO(d_so), .PO(d_po), .COUNT(d_count), .FULL(d_full));

  // Field codes: dut*4 + {0:SO, 1:PO, 2:COUNT, 3:FULL}
  localparam int A = 0, B = 4, C = 8, D = 12;
  localparam int SO = 0, PO = 1, CNT = 2, FUL = 3;

  typedef struct {
    int          tag;
    int          field;
    logic [63:0] exp;
  } sb_entry_t;

  sb_entry_t sb [$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string fname(input int f);
    string d;
    string k;
    case (f / 4)
      0: d = "a"; 1: d = "b"; 2: d = "c"; default: d = "d";
    endcase
    case (f % 4)
      0: k = "so"; 1: k = "po"; 2: k = "count"; default: k = "full";
    endcase
    return {d, "_", k};
  endfunction

  function automatic logic [63:0] actual(input int f);
    case (f)
      A+SO:  return 64'(a_so);   A+PO:  return 64'(a_po);
      A+CNT: return 64'(a_count); A+FUL: return 64'(a_full);
      B+SO:  return 64'(b_so);   B+PO:  return 64'(b_po);
      B+CNT: return 64'(b_count); B+FUL: return 64'(b_full);
      C+SO:  return 64'(c_so);   C+PO:  return 64'(c_po);
      C+CNT: return 64'(c_count); C+FUL: return 64'(c_full);
      D+SO:  return 64'(d_so);   D+PO:  return 64'(d_po);
      D+CNT: return 64'(d_count); D+FUL: return 64'(d_full);
      default: return 64'hDEAD;
    endcase
  endfunction

  // Monitor: every entry tagged with the current cycle is compared at negedge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      sb_entry_t e;
      logic [63:0] act;
      e = sb.pop_front();
      act = actual(e.field);
      checks++;
      if (e.tag != cyc || act !== e.exp) begin
        failures++;
        $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", fname(e.field), cyc, act, e.exp);
      end
    end
  end

  task automatic expect_v(input int f, input logic [63:0] v);
    sb.push_back('{tag: cyc, field: f, exp: v});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ce = 1'b0; load = 1'b0; dir = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    // Test 1: 8-deep 1-bit delay line, single marker bit
    do_reset();
    expect_v(A+SO, 0); expect_v(A+PO, 0); expect_v(A+CNT, 0); expect_v(A+FUL, 0);
    ce = 1'b1; dir = 1'b0; si = 8'd1;
    for (int i = 1; i <= 10; i++) begin
      step();
      si = 8'd0;
      expect_v(A+CNT, (i >= 8) ? 64'd8 : 64'(i));
      expect_v(A+FUL, (i >= 8) ? 64'd1 : 64'd0);
      expect_v(A+SO,  (i == 8) ? 64'd1 : 64'd0);
    end

    // Test 2: parallel load then reverse shift out
    do_reset();
    ce = 1'b1; load = 1'b1; pi = 32'h44332211;
    step();
    load = 1'b0; dir = 1'b1; si = 8'hAA;
    expect_v(B+PO, 64'h44332211); expect_v(B+CNT, 4); expect_v(B+FUL, 1);
    expect_v(B+SO, 64'h11);
    for (int i = 1; i <= 4; i++) begin
      step();
      case (i)
        1: expect_v(B+SO, 64'h22);
        2: expect_v(B+SO, 64'h33);
        3: expect_v(B+SO, 64'h44);
        default: expect_v(B+SO, 64'hAA);
      endcase
    end
    expect_v(B+PO, 64'hAAAAAAAA); expect_v(B+CNT, 4);

    // Test 3: CE=0 blocks LOAD
    do_reset();
    ce = 1'b1; load = 1'b1; dir = 1'b0; pi = 32'h44332211;
    step();
    ce = 1'b0; pi = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_v(B+PO, 64'h44332211); expect_v(B+CNT, 4);
    end

    // Test 4: mid-stream reset to INIT=5
    do_reset();
    expect_v(C+PO, 64'h5555); expect_v(C+CNT, 0); expect_v(C+SO, 64'h5);
    ce = 1'b1; load = 1'b0; dir = 1'b0; si = 8'h1;
    step();
    si = 8'h2;
    step();
    expect_v(C+PO, 64'h5512); expect_v(C+CNT, 2);
    reset = 1'b1; load = 1'b1; pi = 32'hFFFF;
    step();
    reset = 1'b0; load = 1'b0; si = 8'h7;
    expect_v(C+PO, 64'h5555); expect_v(C+CNT, 0); expect_v(C+FUL, 0);
    step();
    expect_v(C+PO, 64'h5557); expect_v(C+CNT, 1);

    // Test 5: direction flip around an intermediate state
    ce = 1'b1; load = 1'b1; pi = 32'h4321;
    step();
    load = 1'b0; dir = 1'b0; si = 8'hF;
    expect_v(C+PO, 64'h4321);
    step();
    ce = 1'b0;
    expect_v(C+PO, 64'h321F); expect_v(C+SO, 64'h3);
    step();
    ce = 1'b1; dir = 1'b1; si = 8'hE;
    expect_v(C+SO, 64'hF);
    step();
    expect_v(C+PO, 64'hE321); expect_v(C+CNT, 4);

    // Test 6: saturation on a 2-deep register
    do_reset();
    ce = 1'b1; dir = 1'b0; si = 8'h1;
    for (int i = 1; i <= 5; i++) begin
      step();
      expect_v(D+CNT, (i >= 2) ? 64'd2 : 64'd1);
      expect_v(D+FUL, (i >= 2) ? 64'd1 : 64'd0);
    end

    ce = 1'b0;
    step();
    step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
